// File: rtl/audio_sched_pkg.sv
// Shared types and defaults for the per-frame audio sample scheduler.
package audio_sched_pkg;

  localparam int unsigned DEFAULT_DATA_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FILTER,
    WAIT_WR,
    WRITE
  } sched_state_e;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// Filter and CODEC handshake bundle between the scheduler (master) and the datapath (slave).
interface audio_sample_scheduler_if
  import audio_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  logic              filt_en;
  logic [DATA_W-1:0] filt_in_left;
  logic [DATA_W-1:0] filt_in_right;
  logic [DATA_W-1:0] filt_out_left;
  logic [DATA_W-1:0] filt_out_right;
  logic              codec_write_ready;
  logic              codec_write;
  logic [DATA_W-1:0] codec_left;
  logic [DATA_W-1:0] codec_right;

  modport master (
    output filt_en, filt_in_left, filt_in_right,
    output codec_write, codec_left, codec_right,
    input  filt_out_left, filt_out_right, codec_write_ready
  );

  modport slave (
    input  filt_en, filt_in_left, filt_in_right,
    input  codec_write, codec_left, codec_right,
    output filt_out_left, filt_out_right, codec_write_ready
  );

endinterface

// File: rtl/audio_sample_scheduler_lrck_edge_sync.sv
// Synchronizes the asynchronous LRCK into CLOCK_50 and emits a registered one-cycle
// pulse on its falling edge; pin-to-pulse latency is SYNC_STAGES+1 cycles (SYNC_STAGES >= 2).
module lrck_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic lrck,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lrck};
      prev_q <= sync_q[SYNC_STAGES-1];
      fall   <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Per-frame audio sequencer: LRCK frame detect, capture, filter strobe, muted warm-up, CODEC write.
// Optional macro SCHED_OVERRUN_CNT_EN enables the saturating dropped-frame counter.
module audio_sample_scheduler
  import audio_sched_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned WARMUP_SAMPLES = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     lrck,
  input  logic [DATA_W-1:0]        rx_left,
  input  logic [DATA_W-1:0]        rx_right,
  audio_sample_scheduler_if.master bus,
  output logic                     muted,
  output logic                     busy,
  output logic [CNT_W-1:0]         overrun_count
);

  localparam int unsigned WARM_W = $clog2(WARMUP_SAMPLES + 1);

  sched_state_e      state_q, state_d;
  logic              pending_q, pending_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [DATA_W-1:0] fin_l_q, fin_l_d, fin_r_q, fin_r_d;
  logic [DATA_W-1:0] cod_l_q, cod_l_d, cod_r_q, cod_r_d;
  logic              filt_en_q, filt_en_d;
  logic              write_q, write_d;
  logic              muted_q, muted_d;
  logic              busy_q, busy_d;
  logic              frame_evt;
  logic              warm_done_c;
  logic              drop_c;

  lrck_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lrck_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .lrck     (lrck),
    .fall     (frame_evt)
  );

  assign warm_done_c = (warm_q >= WARM_W'(WARMUP_SAMPLES));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    warm_d    = warm_q;
    fin_l_d   = fin_l_q;
    fin_r_d   = fin_r_q;
    cod_l_d   = cod_l_q;
    cod_r_d   = cod_r_q;
    drop_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_evt || pending_q) begin
          state_d   = CAPTURE;
          // A fresh frame arriving while draining the pending one stays queued
          pending_d = frame_evt && pending_q;
        end
      end
      CAPTURE: begin
        fin_l_d = rx_left;
        fin_r_d = rx_right;
        state_d = FILTER;
      end
      FILTER: begin
        cod_l_d = warm_done_c ? bus.filt_out_left  : '0;
        cod_r_d = warm_done_c ? bus.filt_out_right : '0;
        if (!warm_done_c) begin
          warm_d = warm_q + WARM_W'(1);
        end
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (bus.codec_write_ready) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // One frame may wait behind the one in flight; anything beyond that is dropped
    if (frame_evt && (state_q != IDLE)) begin
      if (pending_q) begin
        drop_c = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    filt_en_d = (state_d == FILTER);
    write_d   = (state_d == WRITE);
    busy_d    = (state_d != IDLE);
    muted_d   = (warm_d < WARM_W'(WARMUP_SAMPLES));
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      warm_q    <= '0;
      fin_l_q   <= '0;
      fin_r_q   <= '0;
      cod_l_q   <= '0;
      cod_r_q   <= '0;
      filt_en_q <= 1'b0;
      write_q   <= 1'b0;
      muted_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      warm_q    <= warm_d;
      fin_l_q   <= fin_l_d;
      fin_r_q   <= fin_r_d;
      cod_l_q   <= cod_l_d;
      cod_r_q   <= cod_r_d;
      filt_en_q <= filt_en_d;
      write_q   <= write_d;
      muted_q   <= muted_d;
      busy_q    <= busy_d;
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  logic [CNT_W-1:0] ovr_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ovr_q <= '0;
    end else if (drop_c && (ovr_q != '1)) begin
      ovr_q <= ovr_q + CNT_W'(1);
    end
  end

  assign overrun_count = ovr_q;
`else
  logic unused_drop;
  assign unused_drop   = drop_c;
  assign overrun_count = '0;
`endif

  assign bus.filt_en       = filt_en_q;
  assign bus.filt_in_left  = fin_l_q;
  assign bus.filt_in_right = fin_r_q;
  assign bus.codec_write   = write_q;
  assign bus.codec_left    = cod_l_q;
  assign bus.codec_right   = cod_r_q;
  assign muted             = muted_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: directed frames, latency, back-pressure,
// overrun/saturation and mid-write reset; honours SCHED_OVERRUN_CNT_EN.
module tb_audio_sample_scheduler;
  import audio_sched_pkg::*;

  localparam int unsigned DW   = 24;
  localparam int unsigned WU   = 32;
  localparam int unsigned SS   = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned HALF = 32;
`ifdef SCHED_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          m;
  } exp_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b0;
  logic          lrck     = 1'b0;
  logic          ready    = 1'b1;
  logic [DW-1:0] rx_left  = '0;
  logic [DW-1:0] rx_right = '0;
  logic          muted;
  logic          busy;
  logic [CW-1:0] overrun_count;

  exp_t q[$];
  exp_t mon_e;
  int   proc_n   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   n_filt   = 0;

  audio_sample_scheduler_if #(.DATA_W(DW)) bus ();

  // Filter stand-in: a fixed offset while enabled, garbage otherwise to expose mistimed sampling
  assign bus.filt_out_left     = bus.filt_en ? bus.filt_in_left  + DW'(24'h000011) : DW'(24'hBAD000);
  assign bus.filt_out_right    = bus.filt_en ? bus.filt_in_right + DW'(24'h000022) : DW'(24'hBAD111);
  assign bus.codec_write_ready = ready;

  audio_sample_scheduler #(
    .DATA_W         (DW),
    .WARMUP_SAMPLES (WU),
    .SYNC_STAGES    (SS),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .lrck          (lrck),
    .rx_left       (rx_left),
    .rx_right      (rx_right),
    .bus           (bus.master),
    .muted         (muted),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Expected CODEC word for the next processed frame: zero through frame WU, then data+offset
  task automatic push_exp(input logic [DW-1:0] l, input logic [DW-1:0] r);
    exp_t e;
    proc_n++;
    e.l = (proc_n <= int'(WU)) ? '0 : l + DW'(24'h000011);
    e.r = (proc_n <= int'(WU)) ? '0 : r + DW'(24'h000022);
    e.m = (proc_n < int'(WU));
    q.push_back(e);
  endtask

  task automatic lrck_fall();
    lrck = 1'b1;
    tick(HALF);
    lrck = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    rx_left  = l;
    rx_right = r;
    lrck_fall();
    tick(HALF);
  endtask

  // Monitor: counts strobes and checks every CODEC write against the scoreboard head
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (bus.filt_en === 1'b1) n_filt++;
      if (bus.codec_write === 1'b1) begin
        n_writes++;
        check("scoreboard_nonempty_at_write", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("codec_left", 64'(bus.codec_left), 64'(mon_e.l));
          check("codec_right", 64'(bus.codec_right), 64'(mon_e.r));
          check("muted_at_write", 64'(muted), 64'(mon_e.m));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe_at;
    int cw_at;
    int w0;
    int f0;

    // Reset state
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_muted", 64'(muted), 64'd1);
    check("rst_filt_en", 64'(bus.filt_en), 64'd0);
    check("rst_codec_write", 64'(bus.codec_write), 64'd0);
    check("rst_codec_left", 64'(bus.codec_left), 64'd0);
    check("rst_overrun", 64'(overrun_count), 64'd0);
    reset = 1'b1;
    tick(3);

    // Single frame with ready high: filt_en 5 edges and codec_write 7 edges after the pin edge
    rx_left  = 24'h100000;
    rx_right = 24'h0FFFFF;
    push_exp(rx_left, rx_right);
    lrck_fall();
    fe_at = 0;
    cw_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (bus.filt_en === 1'b1 && fe_at == 0) fe_at = i;
      if (bus.codec_write === 1'b1 && cw_at == 0) cw_at = i;
    end
    check("filt_en_latency", 64'(fe_at), 64'd5);
    check("codec_write_latency", 64'(cw_at), 64'd7);
    check("single_frame_filt_pulses", 64'(n_filt), 64'd1);
    check("single_frame_writes", 64'(n_writes), 64'd1);

    // Long back-pressure: one write, one cycle after ready is sampled high
    ready = 1'b0;
    push_exp(rx_left, rx_right);
    lrck_fall();
    tick(5000);
    check("backpressure_no_write", 64'(n_writes), 64'd1);
    check("backpressure_busy", 64'(busy), 64'd1);
    check("backpressure_filt_pulses", 64'(n_filt), 64'd2);
    ready = 1'b1;
    tick(1);
    check("write_after_ready", 64'(bus.codec_write), 64'd1);
    tick(1);
    check("write_single_cycle", 64'(bus.codec_write), 64'd0);
    check("backpressure_writes", 64'(n_writes), 64'd2);
    tick(HALF);

    // Three falling edges while stalled: one in flight, one pending, one dropped
    ready = 1'b0;
    push_exp(rx_left, rx_right);
    push_exp(rx_left, rx_right);
    for (int i = 0; i < 3; i++) begin
      lrck_fall();
      tick(HALF);
    end
    check("overrun_after_3", 64'(overrun_count), OVR_EN ? 64'd1 : 64'd0);
    check("overrun_stall_writes", 64'(n_writes), 64'd2);
    for (int i = 0; i < 300; i++) begin
      lrck_fall();
      tick(HALF);
    end
    check("overrun_saturated", 64'(overrun_count), OVR_EN ? 64'd255 : 64'd0);
    ready = 1'b1;
    tick(40);
    check("overrun_drain_writes", 64'(n_writes), 64'd4);
    check("overrun_drain_empty", 64'(q.size()), 64'd0);
    check("overrun_idle", 64'(busy), 64'd0);

    // Warm-up boundary and beyond with distinct samples per frame
    for (int i = 7; i <= 36; i++) begin
      push_exp(DW'(24'h100000 + i), DW'(24'h0FFFFF - i));
      send_frame(DW'(24'h100000 + i), DW'(24'h0FFFFF - i));
    end
    check("unmuted_after_warmup", 64'(muted), 64'd0);
    check("warmup_filt_equals_writes", 64'(n_filt), 64'(n_writes));

    // Reset while waiting for the CODEC: nothing written, warm-up restarts
    ready = 1'b0;
    push_exp(DW'(24'h0ABCDE), DW'(24'h012345));
    rx_left  = 24'h0ABCDE;
    rx_right = 24'h012345;
    lrck_fall();
    tick(8);
    check("wait_wr_busy", 64'(busy), 64'd1);
    w0 = n_writes;
    #3;
    reset = 1'b0;
    #1;
    q.delete();
    proc_n = 0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_muted", 64'(muted), 64'd1);
    check("midrst_codec_left", 64'(bus.codec_left), 64'd0);
    check("midrst_codec_right", 64'(bus.codec_right), 64'd0);
    check("midrst_filt_in_left", 64'(bus.filt_in_left), 64'd0);
    check("midrst_overrun", 64'(overrun_count), 64'd0);
    tick(1);
    ready = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(10);
    check("midrst_no_write", 64'(n_writes), 64'(w0));
    f0 = n_filt;
    for (int i = 1; i <= 33; i++) begin
      push_exp(DW'(24'h200000 + i), DW'(24'h300000 + i));
      send_frame(DW'(24'h200000 + i), DW'(24'h300000 + i));
      if (i == 31) check("muted_frame31", 64'(muted), 64'd1);
    end
    check("rewarm_writes", 64'(n_writes - w0), 64'd33);
    check("rewarm_filt", 64'(n_filt - f0), 64'd33);
    check("rewarm_unmuted", 64'(muted), 64'd0);
    tick(20);
    check("final_scoreboard_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
